// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - instruction handshake and ALU operand/result bundle for alu_issue
interface alu_issue_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [7:0]  alu_opcode;
  logic        alu_cin;
  logic [15:0] alu_c;
  logic [4:0]  alu_flags;

  // master: instruction source plus the external ALU; slave: the issue block
  modport master (
    output instr_valid, instr, alu_c, alu_flags,
    input  instr_ready, alu_a, alu_b, alu_opcode, alu_cin
  );

  modport slave (
    input  instr_valid, instr, alu_c, alu_flags,
    output instr_ready, alu_a, alu_b, alu_opcode, alu_cin
  );
endinterface

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - serial IDLE/EXEC/WB issue stage with 16x16 register file and psr
module alu_issue (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_if.slave        bus,
  output logic [4:0]        psr,
  input  logic [3:0]        dbg_addr,
  output logic [15:0]       dbg_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]  state;
  logic [15:0] regs [16];
  logic [3:0]  rdest;
  logic [15:0] res_q;
  logic [4:0]  flags_q;
  logic        wr_en;
  logic        psr_en;

  logic [3:0]  op_hi;
  logic [7:0]  opc;
  logic        is_reg;
  logic        is_imm;
  logic        is_cmp;
  logic        is_nop;
  logic [15:0] b_next;

  always_comb begin
    op_hi  = bus.instr[15:12];
    opc    = {bus.instr[15:12], bus.instr[7:4]};
    is_reg = (op_hi == 4'h0) || (op_hi == 4'h8);
    is_imm = op_hi inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hB};
    is_cmp = (opc == 8'h0B) || (opc == 8'h0F) || (op_hi == 4'hB);
    // undecoded op-hi behaves like a NOP but still walks the pipeline
    is_nop = (opc == 8'h00) || !(is_reg || is_imm);
    b_next = 16'h0000;
    if (is_reg)
      b_next = regs[bus.instr[3:0]];
    else if (is_imm)
      b_next = {8'h00, bus.instr[7:0]};
  end

  always_comb begin
    bus.instr_ready = (state == S_IDLE);
    dbg_data        = regs[dbg_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      rdest          <= 4'h0;
      wr_en          <= 1'b0;
      psr_en         <= 1'b0;
      res_q          <= 16'h0000;
      flags_q        <= 5'b00000;
      psr            <= 5'b00000;
      bus.alu_a      <= 16'h0000;
      bus.alu_b      <= 16'h0000;
      bus.alu_opcode <= 8'h00;
      bus.alu_cin    <= 1'b0;
      for (int i = 0; i < 16; i++)
        regs[i] <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            rdest          <= bus.instr[11:8];
            bus.alu_opcode <= opc;
            bus.alu_a      <= regs[bus.instr[11:8]];
            bus.alu_b      <= b_next;
            bus.alu_cin    <= psr[3];
            wr_en          <= !is_nop && !is_cmp;
            psr_en         <= !is_nop;
            state          <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q   <= bus.alu_c;
          flags_q <= bus.alu_flags;
          state   <= S_WB;
        end
        S_WB: begin
          if (wr_en)
            regs[rdest] <= res_q;
          if (psr_en)
            psr <= flags_q;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed table-driven bench for alu_issue with a behavioural ALU
module tb_alu_issue;
  logic        clk;
  logic        rst_n;
  logic [4:0]  psr;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  alu_issue_if bus ();

  alu_issue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .psr      (psr),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural ALU: flags {Z,C,F,N,L}
  logic [16:0] sum;
  always_comb begin
    sum           = 17'h0;
    bus.alu_c     = 16'h0000;
    bus.alu_flags = 5'b00000;
    if (bus.alu_opcode == 8'h05 || bus.alu_opcode[7:4] == 4'h5 ||
        bus.alu_opcode == 8'h07 || bus.alu_opcode[7:4] == 4'h7) begin
      sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} +
            ((bus.alu_opcode == 8'h07 || bus.alu_opcode[7:4] == 4'h7) ? {16'h0, bus.alu_cin} : 17'h0);
      bus.alu_c     = sum[15:0];
      bus.alu_flags = {1'b0, sum[16],
                       (bus.alu_a[15] == bus.alu_b[15]) && (sum[15] != bus.alu_a[15]),
                       2'b00};
    end else if (bus.alu_opcode == 8'h04) begin
      bus.alu_c = ~bus.alu_b;
    end else if (bus.alu_opcode == 8'h0B || bus.alu_opcode[7:4] == 4'hB) begin
      bus.alu_flags = {bus.alu_a == bus.alu_b, 2'b00,
                       $signed(bus.alu_a) < $signed(bus.alu_b),
                       bus.alu_a < bus.alu_b};
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [7:0]  obs_opc;
  logic [15:0] obs_a;
  logic [15:0] obs_b;
  logic        obs_cin;

  task automatic read_reg(input logic [3:0] r, output logic [15:0] v);
    dbg_addr = r;
    #1;
    v = dbg_data;
  endtask

  // one full issue; returns #1 after edge N+2, checking the 2-cycle ready gap
  task automatic issue(input logic [15:0] ins);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus.instr_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_accept", {15'h0, bus.instr_ready}, 16'h1);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    obs_opc = bus.alu_opcode;
    obs_a   = bus.alu_a;
    obs_b   = bus.alu_b;
    obs_cin = bus.alu_cin;
    check("ready_exec", {15'h0, bus.instr_ready}, 16'h0);
    @(posedge clk); #1;
    check("ready_wb", {15'h0, bus.instr_ready}, 16'h0);
    @(posedge clk); #1;
    check("ready_after_wb", {15'h0, bus.instr_ready}, 16'h1);
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [3:0]  reg_idx;
    logic [15:0] reg_val;
    logic [4:0]  exp_psr;
    logic [7:0]  exp_opc;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_cin;
  } vec_t;

  vec_t vecs [11];
  logic [15:0] rv;

  initial begin
    vecs[0]  = '{16'h5105, 4'd1, 16'h0005, 5'b00000, 8'h50, 16'h0000, 16'h0005, 1'b0};
    vecs[1]  = '{16'h5203, 4'd2, 16'h0003, 5'b00000, 8'h50, 16'h0000, 16'h0003, 1'b0};
    vecs[2]  = '{16'h0152, 4'd1, 16'h0008, 5'b00000, 8'h05, 16'h0005, 16'h0003, 1'b0};
    vecs[3]  = '{16'h01B2, 4'd1, 16'h0008, 5'b00000, 8'h0B, 16'h0008, 16'h0003, 1'b0};
    vecs[4]  = '{16'h02B1, 4'd2, 16'h0003, 5'b00011, 8'h0B, 16'h0003, 16'h0008, 1'b0};
    vecs[5]  = '{16'h0340, 4'd3, 16'hFFFF, 5'b00000, 8'h04, 16'h0000, 16'h0000, 1'b0};
    vecs[6]  = '{16'h0353, 4'd3, 16'hFFFE, 5'b01000, 8'h05, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[7]  = '{16'h0470, 4'd4, 16'h0001, 5'b00000, 8'h07, 16'h0000, 16'h0000, 1'b1};
    vecs[8]  = '{16'h02B1, 4'd2, 16'h0003, 5'b00011, 8'h0B, 16'h0003, 16'h0008, 1'b0};
    vecs[9]  = '{16'h0300, 4'd3, 16'hFFFE, 5'b00011, 8'h00, 16'hFFFE, 16'h0000, 1'b0};
    vecs[10] = '{16'hC1FF, 4'd1, 16'h0008, 5'b00011, 8'hCF, 16'h0008, 16'h0000, 1'b0};

    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    dbg_addr        = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {15'h0, bus.instr_ready}, 16'h1);
    check("rst_psr", {11'h0, psr}, 16'h0);
    check("rst_opcode", {8'h0, bus.alu_opcode}, 16'h0);
    check("rst_alu_a", bus.alu_a, 16'h0);
    read_reg(4'd15, rv);
    check("rst_r15", rv, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].ins);
      check($sformatf("v%0d_opcode", i), {8'h0, obs_opc}, {8'h0, vecs[i].exp_opc});
      check($sformatf("v%0d_alu_a", i), obs_a, vecs[i].exp_a);
      check($sformatf("v%0d_alu_b", i), obs_b, vecs[i].exp_b);
      check($sformatf("v%0d_cin", i), {15'h0, obs_cin}, {15'h0, vecs[i].exp_cin});
      read_reg(vecs[i].reg_idx, rv);
      check($sformatf("v%0d_reg", i), rv, vecs[i].reg_val);
      check($sformatf("v%0d_psr", i), {11'h0, psr}, {11'h0, vecs[i].exp_psr});
    end

    // instr_valid held high with changing instr during EXEC/WB
    @(negedge clk);
    bus.instr       = 16'h5109;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr = 16'h5505;
    check("hold_opc_n1", {8'h0, bus.alu_opcode}, 16'h0050);
    read_reg(4'd1, rv);
    check("hold_old_r1_exec", rv, 16'h0008);
    @(posedge clk); #1;
    bus.instr = 16'h56AA;
    check("hold_a_wb", bus.alu_a, 16'h0008);
    check("hold_b_wb", bus.alu_b, 16'h0009);
    check("hold_opc_wb", {8'h0, bus.alu_opcode}, 16'h0050);
    check("hold_ready_wb", {15'h0, bus.instr_ready}, 16'h0);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    read_reg(4'd1, rv);
    check("hold_r1", rv, 16'h0011);
    repeat (3) @(posedge clk);
    #1;
    read_reg(4'd5, rv);
    check("hold_no_r5", rv, 16'h0000);
    read_reg(4'd6, rv);
    check("hold_no_r6", rv, 16'h0000);

    // reset pulse while in WB aborts the write
    @(negedge clk);
    bus.instr       = 16'h5107;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rstwb_ready", {15'h0, bus.instr_ready}, 16'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    read_reg(4'd1, rv);
    check("rstwb_r1", rv, 16'h0000);
    read_reg(4'd3, rv);
    check("rstwb_r3", rv, 16'h0000);
    check("rstwb_psr", {11'h0, psr}, 16'h0);
    check("rstwb_ready_after", {15'h0, bus.instr_ready}, 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
